shared_mult_scheduler: RTL and testbench
========================================

SHARED_MULT_SCHEDULER -- requirements
Module: shared_mult_scheduler

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 req0, req1  input  1 each  requester n asks for one multiply; held high until gntn.
REQ-004 a0, b0, a1, b1  input  8 each  operands of requester n; sampled only on the accepting edge.
REQ-005 gnt0, gnt1  output  1 each  registered one-cycle pulse: requester n accepted.
REQ-006 result  output  8  product modulo 256, low byte of a*b.
REQ-007 result_id  output  1  requester that owns result (0/1).
REQ-008 result_valid  output  1  result and result_id valid.
REQ-009 result_ready  input  1  consumer accepts result.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL be a three-state FSM (IDLE, RUN, DONE) plus:
- 3-bit step counter
- operand registers a_reg, b_reg
- 8-bit accumulator acc
- round-robin pointer last.
REQ-012 IDLE, at least one req high: SHALL accept at that edge and go to RUN.
- Acceptance latches the winner's a/b, clears acc and counter, sets last = winner.
- The winner's gnt is high for exactly the following cycle.
REQ-013 Arbitration SHALL grant the sole requester; if both are high, it SHALL grant the requester other than last.
REQ-014 Requests arriving while busy SHALL be ignored, not queued; a req dropped before its gnt SHALL cause no grant.
REQ-015 Each RUN edge with step k SHALL add (a_reg << k) truncated to 8 bits to acc when b_reg[k]=1, then increment k, all arithmetic modulo 256.
REQ-016 The edge performing step 7 SHALL move to DONE; result_valid SHALL therefore first be high 8 cycles after the gnt cycle.
REQ-017 In DONE: result_valid=1; result=acc and result_id stay stable until result_ready=1 is sampled.
- At that edge the FSM SHALL return to IDLE and drop result_valid.
REQ-018 Back-to-back: no grant on the DONE-exit edge; earliest next gnt is one cycle after result_valid falls.
REQ-019 Operand 0 (a or b) SHALL still occupy full RUN latency (without REQ-025 feature) and yield result 0.
REQ-020 result SHALL be bitwise equal to the low 8 bits of a*b for all 65536 operand pairs.

Reset
REQ-021 rst high SHALL immediately force IDLE, counter=0, acc=0, and last=1 so req0 wins the first tie.
REQ-022 rst high SHALL drive gnt0=gnt1=0, result=0, result_id=0, result_valid=0, busy=0 without waiting for clk.
REQ-023 Reset mid-RUN or mid-DONE SHALL discard the in-flight operation; no result_valid SHALL follow.
REQ-024 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro MULT_EARLY_TERM_EN:
- Defined: a RUN edge at step k SHALL go to DONE when b_reg bits above k are all zero, so latency is index(highest set bit of b)+1 cycles, minimum 1.
- Undefined: RUN always lasts exactly 8 cycles.
- Results are identical in both builds.

Verification
REQ-026 req0, a0=3, b0=5 -> gnt0 pulse; result_valid 8 cycles later; result=15, result_id=0.
REQ-027 req1, a1=20, b1=20 -> result=144 (400 mod 256), result_id=1.
REQ-028 req0 and req1 both held from reset release -> gnt0, then gnt1 after the first result handshake, then gnt0 again.
REQ-029 result_ready low 5 cycles in DONE, new req0 pulsed -> result stable, busy=1, no gnt; handshake then IDLE.
REQ-030 rst pulsed at RUN step 4 -> all outputs 0 asynchronously; no result_valid afterwards.
REQ-031 a0=7, b0=1 -> result=7 with result_valid 1 cycle after gnt when MULT_EARLY_TERM_EN is defined, 8 cycles after gnt when undefined.

Source files
------------

// File: rtl/shared_mult_scheduler.sv
// Two-requester shift-add 8x8 multiplier with round-robin arbitration.
// Define MULT_EARLY_TERM_EN to finish RUN once no higher b bits remain.
module shared_mult_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic       result_ready,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] result,
  output logic       result_id,
  output logic       result_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] step;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [7:0] acc;
  logic [7:0] addend;
  logic       last;
  logic       owner;
  logic       win;
  logic       accept;
  logic       step_last;

  // Arbitration: sole requester wins, a tie goes to the one not served last
  always_comb begin
    win    = (req0 && req1) ? ~last : req1;
    accept = (state == IDLE) && (req0 || req1);
    addend = a_reg << step;
`ifdef MULT_EARLY_TERM_EN
    step_last = (b_reg >> step) <= 8'd1;
`else
    step_last = (step == 3'd7);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)       state_nx = RUN;
      RUN:  if (step_last)    state_nx = DONE;
      DONE: if (result_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add steps and grant pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step  <= 3'd0;
      a_reg <= 8'd0;
      b_reg <= 8'd0;
      acc   <= 8'd0;
      last  <= 1'b1;
      owner <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      if (accept) begin
        a_reg <= win ? a1 : a0;
        b_reg <= win ? b1 : b0;
        acc   <= 8'd0;
        step  <= 3'd0;
        last  <= win;
        owner <= win;
        gnt0  <= ~win;
        gnt1  <= win;
      end else if (state == RUN) begin
        if (b_reg[step]) acc <= acc + addend;
        step <= step + 3'd1;
      end
    end
  end

  // Outputs decoded from state and registers
  always_comb begin
    result       = acc;
    result_id    = owner;
    result_valid = (state == DONE);
    busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_shared_mult_scheduler.sv
// Self-checking bench for shared_mult_scheduler.
// Vector table, scoreboard queue and multi-cycle corner sequences.
module tb_shared_mult_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic       result_ready;
  logic       gnt0, gnt1;
  logic [7:0] result;
  logic       result_id;
  logic       result_valid;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit       id;
    bit [7:0] a;
    bit [7:0] b;
    bit [7:0] exp;
    int       hold;
  } vec_t;

  typedef struct {
    bit       id;
    bit [7:0] res;
  } sb_t;

  vec_t vt[10];
  sb_t  sb[$];

  shared_mult_scheduler dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .result_ready(result_ready),
    .gnt0(gnt0), .gnt1(gnt1),
    .result(result), .result_id(result_id),
    .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(bit [7:0] b);
    int l;
`ifdef MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
`else
    l = 8;
`endif
    return l;
  endfunction

  // Wait for result_valid; returns cycles counted since the gnt cycle
  task automatic wait_valid(output int n, output bit seen);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = result_valid;
    end
  endtask

  task automatic pop_check(string tag);
    sb_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_id"}, result_id, e.id);
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("rv_drop", result_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic run_op(bit id, bit [7:0] a, bit [7:0] b,
                        bit [7:0] exp, int hold);
    bit seen;
    int n;
    if (id) begin req1 = 1; a1 = a; b1 = b; end
    else    begin req0 = 1; a0 = a; b0 = b; end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = id ? gnt1 : gnt0;
    end
    req0 = 0;
    req1 = 0;
    chk("gnt_seen", seen, 1);
    if (!seen) return;
    chk("gnt_other", id ? gnt0 : gnt1, 0);
    sb.push_back('{id: id, res: exp});
    wait_valid(n, seen);
    chk("latency", n, exp_lat(b));
    if (!seen) begin
      void'(sb.pop_front());
      return;
    end
    pop_check("op");
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_result", result, exp);
      chk("hold_valid", result_valid, 1);
    end
    handshake();
  endtask

  initial begin
    bit seen;
    bit any;
    int n;
    bit [7:0] ra, rb;

    vt[0] = '{0,   3,   5,  15, 0};
    vt[1] = '{1,  20,  20, 144, 1};
    vt[2] = '{0,   7,   1,   7, 0};
    vt[3] = '{1,   0, 200,   0, 2};
    vt[4] = '{0, 255, 255,   1, 0};
    vt[5] = '{1,  16,  16,   0, 0};
    vt[6] = '{0, 200,   0,   0, 0};
    vt[7] = '{1,  13,  11, 143, 0};
    vt[8] = '{0, 128,   3, 128, 1};
    vt[9] = '{1, 255,   2, 254, 0};

    rst = 1; result_ready = 0;
    req0 = 1; req1 = 1;
    a0 = 3; b0 = 5; a1 = 20; b1 = 20;
    #2;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_result", result, 0);
    chk("rst_rid", result_id, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    rst = 0;

    // Tie from reset release: req0, then req1, then req0
    tick();
    chk("tie1_gnt0", gnt0, 1);
    chk("tie1_gnt1", gnt1, 0);
    req0 = 0;
    sb.push_back('{id: 0, res: 15});
    wait_valid(n, seen);
    chk("tie1_lat", n, exp_lat(5));
    pop_check("tie1");
    result_ready = 1;
    tick();
    result_ready = 0;
    chk("b2b_rv", result_valid, 0);
    chk("b2b_no_gnt", gnt1, 0);
    tick();
    chk("tie2_gnt1", gnt1, 1);
    req1 = 0;
    req0 = 1;
    sb.push_back('{id: 1, res: 144});
    any = 0;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = result_valid;
      any |= gnt0;
    end
    chk("tie2_lat", n, exp_lat(20));
    chk("busy_ignores_req", any, 0);
    pop_check("tie2");
    result_ready = 1;
    tick();
    result_ready = 0;
    chk("tie3_exit_gnt", gnt0, 0);
    req1 = 1;
    tick();
    chk("tie3_gnt0", gnt0, 1);
    chk("tie3_gnt1", gnt1, 0);
    req0 = 0;
    req1 = 0;
    sb.push_back('{id: 0, res: 15});
    wait_valid(n, seen);
    pop_check("tie3");
    handshake();
    tick();

    for (int i = 0; i < 10; i++)
      run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].exp, vt[i].hold);

    // Stall in DONE with a short req0 pulse that must be dropped
    run_op(0, 9, 9, 81, 0);
    req0 = 1; a0 = 9; b0 = 9;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = gnt0;
    end
    req0 = 0;
    sb.push_back('{id: 0, res: 81});
    wait_valid(n, seen);
    pop_check("stall");
    any = 0;
    for (int i = 0; i < 5; i++) begin
      req0 = (i == 2);
      tick();
      any |= (result != 8'd81) || !busy || gnt0 || !result_valid;
    end
    req0 = 0;
    chk("stall_stable", any, 0);
    handshake();
    any = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      any |= gnt0 | busy;
    end
    chk("dropped_req_no_gnt", any, 0);

    // Asynchronous reset during RUN step 4
    req0 = 1; a0 = 7; b0 = 255;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = gnt0;
    end
    req0 = 0;
    chk("abort_gnt", seen, 1);
    repeat (4) tick();
    chk("abort_busy", busy, 1);
    #2;
    rst = 1;
    #1;
    chk("arst_gnt0", gnt0, 0);
    chk("arst_gnt1", gnt1, 0);
    chk("arst_result", result, 0);
    chk("arst_rid", result_id, 0);
    chk("arst_rv", result_valid, 0);
    chk("arst_busy", busy, 0);
    tick();
    rst = 0;
    any = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      any |= result_valid | busy;
    end
    chk("abort_no_result", any, 0);

    // Random operands checked against the low byte of a*b
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(1'($urandom_range(0, 1)), ra, rb, 8'(ra * rb),
             $urandom_range(0, 2));
    end

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
